// File: rtl/and_array_shift_add_mult_if.sv
// Start/done handshake bundle for the shift-add multiplier: operands and
// start in, busy/done and the product register out.
interface and_array_shift_add_mult_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] res;

  modport master (output start, a, b, input busy, done, res);
  modport slave  (input start, a, b, output busy, done, res);
endinterface

// File: rtl/and_array_shift_add_mult.sv
// Sequential unsigned multiplier: an AND array gates the multiplicand by one
// multiplier bit per cycle, the result is added into a right-shifting accumulator.
// Optional macro AND_MULT_ZERO_BYPASS_EN: a zero operand skips CALC and goes straight to DONE.
module and_array_shift_add_mult #(
  parameter int WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  and_array_shift_add_mult_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state, state_next;
  logic [WIDTH-1:0]     a_reg, b_reg, pp;
  logic [2*WIDTH-1:0]   acc, acc_next, res_reg;
  logic [WIDTH:0]       sum;
  logic [CW-1:0]        count;
  logic                 last, bypass, busy, done;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    bypass     = 1'b0;
`ifdef AND_MULT_ZERO_BYPASS_EN
    bypass     = (bus.a == '0) || (bus.b == '0);
`endif

    // Carry-out of the upper-half add becomes the new MSB after the shift.
    pp       = a_reg & {WIDTH{b_reg[0]}};
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, pp};
    acc_next = {sum, acc[WIDTH-1:1]};
    last     = (count == CW'(WIDTH - 1));

    case (state)
      IDLE: if (bus.start) state_next = bypass ? DONE : CALC;
      CALC: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state   <= IDLE;
      a_reg   <= '0;
      b_reg   <= '0;
      acc     <= '0;
      count   <= '0;
      res_reg <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (bus.start) begin
          a_reg <= bus.a;
          b_reg <= bus.b;
          acc   <= '0;
          count <= '0;
          if (bypass) res_reg <= '0;
        end
        CALC: begin
          acc   <= acc_next;
          b_reg <= b_reg >> 1;
          count <= count + 1'b1;
          if (last) res_reg <= acc_next;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.res  = res_reg;
endmodule
